// File: rtl/si_tag_pkg.sv
// Shared types and constants for the si tag-rate meter.
// Tag channel field location and the window/output FSM state encodings.
package si_tag_pkg;
  localparam int TAG_CH_LSB = 0;
  localparam int TAG_CH_W = 6;
  localparam logic [3:0] TAG_KEEP_FULL = 4'hF;

  typedef logic [TAG_CH_W-1:0] tag_channel_t;

  typedef enum logic {
    W_IDLE,
    W_RUN
  } win_state_t;

  typedef enum logic {
    O_IDLE,
    O_SEND
  } out_state_t;
endpackage

// File: rtl/si_rate_serializer.sv
// Serializes one window snapshot into a per-channel AXI-Stream packet.
// Snapshots arriving while a packet is in flight are counted as dropped.
module si_rate_serializer
  import si_tag_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                win_end,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] snap,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tvalid,
  output logic [COUNT_WIDTH-1:0]              m_axis_tdata,
  output logic [5:0]                          m_axis_tuser,
  output logic                                m_axis_tlast,
  output logic [15:0]                         dropped_windows
);

  out_state_t state, state_nx;
  tag_channel_t idx;
  logic [COUNT_WIDTH-1:0] hold [NUM_CHANNELS];
  logic last;

  assign last = (idx == tag_channel_t'(NUM_CHANNELS - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      O_IDLE: if (win_end) state_nx = O_SEND;
      O_SEND: if (m_axis_tready && last) state_nx = O_IDLE;
      default: state_nx = O_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state == O_SEND);
    m_axis_tdata = '0;
    m_axis_tuser = '0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tuser = idx;
      m_axis_tlast = last;
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (idx == tag_channel_t'(i)) m_axis_tdata = hold[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= O_IDLE;
      idx <= '0;
      dropped_windows <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) hold[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == O_IDLE && win_end) begin
        idx <= '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
          hold[i] <= snap[i*COUNT_WIDTH +: COUNT_WIDTH];
      end
      if (state == O_SEND && m_axis_tready)
        idx <= last ? '0 : idx + tag_channel_t'(1);
      // Includes the cycle the last beat is accepted.
      if (state == O_SEND && win_end && dropped_windows != '1)
        dropped_windows <= dropped_windows + 16'd1;
    end
  end

endmodule

// File: rtl/si_tag_rate_meter.sv
// Per-channel tag-rate meter: counts accepted tags per channel over a
// programmable window and emits each window's counts as a packet.
module si_tag_rate_meter
  import si_tag_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic [3:0]             s_axis_tkeep,
  input  logic [31:0]            s_axis_tuser,
  input  logic                   enable,
  input  logic [31:0]            window_cycles,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [COUNT_WIDTH-1:0] m_axis_tdata,
  output logic [5:0]             m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic [15:0]            dropped_windows,
  output logic [31:0]            out_of_range_tags
);

  win_state_t state, state_nx;
  logic [31:0] len, timer;
  logic [COUNT_WIDTH-1:0] counts [NUM_CHANNELS];
  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] snap;
  tag_channel_t ch;
  logic accept, in_range, keep_on, win_end;
  logic unused_ok;

  assign unused_ok = ^{s_axis_tlast, s_axis_tuser, s_axis_tdata};
  assign s_axis_tready = ~rst;

  assign ch = s_axis_tdata[TAG_CH_LSB +: TAG_CH_W];
  assign accept = s_axis_tvalid && (s_axis_tkeep == TAG_KEEP_FULL);
  assign in_range = (32'(ch) < NUM_CHANNELS);
  assign keep_on = enable && (window_cycles != 32'd0);
  assign win_end = (state == W_RUN) && keep_on && (timer == len - 32'd1);

  // Counts after this cycle's tag, so the snapshot includes it.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      snap[i*COUNT_WIDTH +: COUNT_WIDTH] = counts[i];
      if (accept && in_range && ch == tag_channel_t'(i) && counts[i] != '1)
        snap[i*COUNT_WIDTH +: COUNT_WIDTH] = counts[i] + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      W_IDLE: if (keep_on) state_nx = W_RUN;
      W_RUN: if (!keep_on) state_nx = W_IDLE;
      default: state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W_IDLE;
      len <= '0;
      timer <= '0;
      out_of_range_tags <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) counts[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept && !in_range && out_of_range_tags != '1)
        out_of_range_tags <= out_of_range_tags + 32'd1;
      if (state != W_RUN || !keep_on || win_end) begin
        for (int i = 0; i < NUM_CHANNELS; i++) counts[i] <= '0;
        timer <= '0;
        if (keep_on) len <= window_cycles;
      end else begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          counts[i] <= snap[i*COUNT_WIDTH +: COUNT_WIDTH];
        timer <= timer + 32'd1;
      end
    end
  end

  si_rate_serializer #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_ser (
    .clk(clk),
    .rst(rst),
    .win_end(win_end),
    .snap(snap),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .dropped_windows(dropped_windows)
  );

endmodule
